// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared types and constants for the LSU data-memory front-end.
// Access-size and FSM-state enums, byte-mask constants and small helper functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input size_e sz);
        case (sz)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // Natural alignment: the low address bits covered by the access width must be zero.
    function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0] != 1'b0;
            SZ_W:    return off[1:0] != 2'b00;
            default: return off != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response handshake plus data-memory port bundle for lsu_dmem_ctrl.
// slave: the LSU itself; master: the pipeline stage and memory around it.
interface lsu_dmem_ctrl_if #(
    parameter int XLEN = 64
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [1:0]      req_size;
    logic            req_unsigned;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            dmem_en;
    logic            dmem_wen;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_wmask;
    logic [XLEN-1:0] dmem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_ready, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dmem_en, dmem_wen, dmem_addr, dmem_wdata, dmem_wmask
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        output resp_ready, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dmem_en, dmem_wen, dmem_addr, dmem_wdata, dmem_wmask
    );
endinterface

// File: rtl/lsu_dmem_ctrl_align.sv
// Combinational alignment datapath: misalignment check, byte mask, store shift, load extend.
// The check port looks at the incoming request; the datapath ports look at the latched one.
import lsu_pkg::*;

module lsu_align #(
    parameter int XLEN = 64
) (
    input  logic [2:0]      i_chk_off,
    input  size_e           i_chk_size,
    output logic            o_misaligned,
    input  logic [2:0]      i_off,
    input  size_e           i_size,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [7:0]      o_wmask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);
    logic [5:0]      w_bit_sh;
    logic [XLEN-1:0] w_rsh;

    assign o_misaligned = is_misaligned(i_chk_size, i_chk_off);
    assign w_bit_sh     = {i_off, 3'b000};
    assign o_wmask      = size_mask(i_size) << i_off;
    assign o_wdata      = i_wdata << w_bit_sh;
    assign w_rsh        = i_rdata >> w_bit_sh;

    always_comb begin
        o_rdata = w_rsh;
        case (i_size)
            SZ_B:    o_rdata = {{(XLEN-8){~i_unsigned & w_rsh[7]}},   w_rsh[7:0]};
            SZ_H:    o_rdata = {{(XLEN-16){~i_unsigned & w_rsh[15]}}, w_rsh[15:0]};
            SZ_W:    o_rdata = {{(XLEN-32){~i_unsigned & w_rsh[31]}}, w_rsh[31:0]};
            default: o_rdata = w_rsh;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store front-end for the ram_2r1w data port: one request in flight,
// single-cycle memory access, registered response with misalignment flag and event counters.
import lsu_pkg::*;

module lsu_dmem_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_dmem_ctrl_if.slave   lsu,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    state_e            r_state;
    state_e            w_next;

    logic              r_wen;
    logic              r_unsigned;
    size_e             r_size;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;

    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;
    logic [CNT_W-1:0]  r_ld_cnt;
    logic [CNT_W-1:0]  r_st_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_accept;
    logic              w_access;
    logic              w_resp_hs;
    logic              w_dmem_go;
    logic              w_req_mis;
    logic [7:0]        w_wmask8;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_rdata_ext;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_chk_off    (lsu.req_addr[2:0]),
        .i_chk_size   (size_e'(lsu.req_size)),
        .o_misaligned (w_req_mis),
        .i_off        (r_addr[2:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata),
        .i_rdata      (lsu.dmem_rdata),
        .o_wmask      (w_wmask8),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        lsu.req_ready  = 1'b0;
        lsu.resp_valid = 1'b0;
        w_access       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                lsu.req_ready = 1'b1;
                if (lsu.req_valid) w_next = w_req_mis ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                w_access = 1'b1;
                w_next   = ST_RESP;
            end
            ST_RESP: begin
                lsu.resp_valid = 1'b1;
                lsu.req_ready  = lsu.resp_ready;
                if (lsu.resp_ready) begin
                    if (lsu.req_valid) w_next = w_req_mis ? ST_RESP : ST_ACCESS;
                    else               w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        w_accept  = lsu.req_valid & lsu.req_ready;
        w_resp_hs = lsu.resp_valid & lsu.resp_ready;
    end

    // Reset gates the memory strobes combinationally so no access escapes in a reset cycle.
    assign w_dmem_go       = w_access & rst_n;
    assign lsu.dmem_en     = w_dmem_go;
    assign lsu.dmem_wen    = w_dmem_go & r_wen;
    assign lsu.dmem_addr   = w_dmem_go ? {r_addr[XLEN-1:3], 3'b000} : '0;
    assign lsu.dmem_wdata  = w_dmem_go ? w_wdata_sh : '0;
    assign lsu.dmem_wmask  = w_dmem_go ? {{(XLEN-8){1'b0}}, w_wmask8} : '0;
    assign lsu.resp_rdata  = r_resp_rdata;
    assign lsu.resp_err    = r_resp_err;
    assign ld_cnt          = r_ld_cnt;
    assign st_cnt          = r_st_cnt;
    assign err_cnt         = r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen        <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= SZ_B;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_ld_cnt     <= '0;
            r_st_cnt     <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_wen        <= lsu.req_wen;
                r_unsigned   <= lsu.req_unsigned;
                r_size       <= size_e'(lsu.req_size);
                r_addr       <= lsu.req_addr;
                r_wdata      <= lsu.req_wdata;
                r_resp_rdata <= '0;
                r_resp_err   <= w_req_mis;
            end else if (w_resp_hs) begin
                r_resp_rdata <= '0;
                r_resp_err   <= 1'b0;
            end
            if (w_access) begin
                r_resp_rdata <= r_wen ? '0 : w_rdata_ext;
                r_resp_err   <= 1'b0;
            end
            if (w_resp_hs) begin
                if (r_resp_err)  r_err_cnt <= r_err_cnt + 1'b1;
                else if (r_wen)  r_st_cnt  <= r_st_cnt + 1'b1;
                else             r_ld_cnt  <= r_ld_cnt + 1'b1;
            end
        end
    end

endmodule
